// File: rtl/delay_pkg.sv
// Shared types and constants for the programmable delay timer family.
package delay_pkg;

   localparam int unsigned CNT_W_DEF         = 18;
   localparam int unsigned PS_W_DEF          = 8;
   localparam int unsigned DEFAULT_DELAY_2MS = 200000;
   // Remaining-count value at which the next tick is the terminal one.
   localparam int unsigned TC_REMAIN         = 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/delay_timer_if.sv
// Control/status bundle between a sequencer (master) and the delay timer (slave).
interface delay_timer_if
   import delay_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned PS_W  = PS_W_DEF
);
   logic             start;
   logic             abort;
   logic             periodic;
   logic             use_default;
   logic [CNT_W-1:0] delay_val;
   logic [PS_W-1:0]  prescale;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] remaining;

   modport master (
      output start, abort, periodic, use_default, delay_val, prescale,
      input  busy, done, remaining
   );

   modport slave (
      input  start, abort, periodic, use_default, delay_val, prescale,
      output busy, done, remaining
   );
endinterface

// File: rtl/tick_prescaler.sv
// Emits a one-cycle tick every period+1 enabled clocks; clear restarts the count at 0.
// Tick is combinational from the count register, so it lines up with the cycle that wraps.
module tick_prescaler #(
   parameter int unsigned PS_W = 8
)(
   input  logic            clock,
   input  logic            reset_n,
   input  logic            clear,
   input  logic            enable,
   input  logic [PS_W-1:0] period,
   output logic            tick
);

   logic [PS_W-1:0] cnt_q;

   assign tick = enable && (cnt_q == period);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= (cnt_q == period) ? '0 : cnt_q + PS_W'(1);
      end
   end

endmodule

// File: rtl/delay_timer.sv
// Programmable one-shot/periodic delay timer with prescaler, retrigger and abort.
// done rises D_eff*(P_eff+1) clocks after the accepted start; all outputs registered.
module delay_timer
   import delay_pkg::*;
#(
   parameter int unsigned CNT_W         = CNT_W_DEF,
   parameter int unsigned PS_W          = PS_W_DEF,
   parameter int unsigned DEFAULT_DELAY = DEFAULT_DELAY_2MS
)(
   input  logic         clock,
   input  logic         reset_n,
   delay_timer_if.slave bus
);

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_RUN  = RUN;

   if (longint'(DEFAULT_DELAY) >= (longint'(1) << CNT_W)) begin : g_bad_default
      $error("DEFAULT_DELAY does not fit in CNT_W bits");
   end

   logic [0:0]       state_q;
   logic             start_q;
   logic             done_q;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] d_lat_q;
   logic [PS_W-1:0]  p_lat_q;
   logic [CNT_W-1:0] d_eff;
   logic             go;
   logic             tick;
   logic             terminal;

   // A held start only re-arms from IDLE; in RUN only a fresh rising edge retriggers.
   assign go = bus.start && !bus.abort && ((state_q == ST_IDLE) || !start_q);

   always_comb begin
      d_eff = bus.delay_val;
      if (bus.delay_val == '0) begin
         d_eff = bus.use_default ? CNT_W'(DEFAULT_DELAY) : CNT_W'(1);
      end
   end

   assign terminal = (state_q == ST_RUN) && tick && (rem_q == CNT_W'(TC_REMAIN));

   tick_prescaler #(.PS_W(PS_W)) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (bus.abort || go || terminal),
      .enable  (state_q == ST_RUN),
      .period  (p_lat_q),
      .tick    (tick)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         rem_q   <= '0;
         d_lat_q <= '0;
         p_lat_q <= '0;
      end else begin
         start_q <= bus.start;
         done_q  <= 1'b0;
         if (bus.abort) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
         end else if (go) begin
            // Retrigger wins over a coincident terminal count: no done for the old interval.
            state_q <= ST_RUN;
            rem_q   <= d_eff;
            d_lat_q <= d_eff;
            p_lat_q <= bus.prescale;
         end else if (terminal) begin
            done_q <= 1'b1;
            if (bus.periodic) begin
               rem_q <= d_lat_q;
            end else begin
               state_q <= ST_IDLE;
               rem_q   <= '0;
            end
         end else if ((state_q == ST_RUN) && tick && (rem_q != '0)) begin
            rem_q <= rem_q - CNT_W'(1);
         end
      end
   end

   assign bus.busy      = (state_q == ST_RUN);
   assign bus.done      = done_q;
   assign bus.remaining = rem_q;

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer; t counts clock edges after the edge that accepted start.
module tb_delay_timer;
   import delay_pkg::*;

   logic clock = 1'b0;
   logic reset_n;

   delay_timer_if #(.CNT_W(18), .PS_W(8)) bus ();

   delay_timer #(.CNT_W(18), .PS_W(8), .DEFAULT_DELAY(200000)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic setup(input logic [17:0] d, input logic [7:0] p, input logic per, input logic dflt);
      bus.delay_val   = d;
      bus.prescale    = p;
      bus.periodic    = per;
      bus.use_default = dflt;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      setup(18'd0, 8'd0, 1'b0, 1'b0);
      #2;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_rem",  32'(bus.remaining), 0);
      repeat (3) step();
      reset_n = 1'b1;
      step();

      // One-shot D=10 P=4: 50 clocks total, remaining steps every 5 clocks
      setup(18'd10, 8'd4, 1'b0, 1'b0);
      pulse_start();
      chk("os_busy0", 32'(bus.busy), 1);
      chk("os_rem0",  32'(bus.remaining), 10);
      for (int t = 1; t <= 55; t++) begin
         step();
         chk($sformatf("os_done@%0d", t), 32'(bus.done), (t == 50) ? 1 : 0);
         chk($sformatf("os_busy@%0d", t), 32'(bus.busy), (t < 50) ? 1 : 0);
         chk($sformatf("os_rem@%0d", t), 32'(bus.remaining), (t < 50) ? 10 - t / 5 : 0);
      end

      // Periodic D=4 P=1: done at 8,16,24; mid-run config change ignored; periodic dropped before 24
      setup(18'd4, 8'd1, 1'b1, 1'b0);
      pulse_start();
      for (int t = 1; t <= 40; t++) begin
         step();
         chk($sformatf("per_done@%0d", t), 32'(bus.done), (t == 8 || t == 16 || t == 24) ? 1 : 0);
         chk($sformatf("per_busy@%0d", t), 32'(bus.busy), (t < 24) ? 1 : 0);
         chk($sformatf("per_rem@%0d", t), 32'(bus.remaining), (t < 24) ? 4 - (t % 8) / 2 : 0);
         if (t == 3) begin
            bus.delay_val = 18'd7;
            bus.prescale  = 8'd0;
         end
         if (t == 20) bus.periodic = 1'b0;
      end

      // Retrigger at 15 with D=5: single done at 20
      setup(18'd20, 8'd0, 1'b0, 1'b0);
      pulse_start();
      for (int t = 1; t <= 30; t++) begin
         step();
         chk($sformatf("rt_done@%0d", t), 32'(bus.done), (t == 20) ? 1 : 0);
         chk($sformatf("rt_rem@%0d", t), 32'(bus.remaining),
             (t < 15) ? 20 - t : (t < 20) ? 5 - (t - 15) : 0);
         if (t == 14) begin
            bus.start     = 1'b1;
            bus.delay_val = 18'd5;
         end
         if (t == 15) bus.start = 1'b0;
      end

      // Retrigger landing on the terminal edge suppresses that done
      setup(18'd5, 8'd0, 1'b0, 1'b0);
      pulse_start();
      for (int t = 1; t <= 12; t++) begin
         step();
         chk($sformatf("rtc_done@%0d", t), 32'(bus.done), (t == 8) ? 1 : 0);
         chk($sformatf("rtc_busy@%0d", t), 32'(bus.busy), (t < 8) ? 1 : 0);
         chk($sformatf("rtc_rem@%0d", t), 32'(bus.remaining),
             (t < 5) ? 5 - t : (t < 8) ? 3 - (t - 5) : 0);
         if (t == 4) begin
            bus.start     = 1'b1;
            bus.delay_val = 18'd3;
         end
         if (t == 5) bus.start = 1'b0;
      end

      // Abort coinciding with terminal count: no done, back to IDLE
      setup(18'd20, 8'd0, 1'b0, 1'b0);
      pulse_start();
      for (int t = 1; t <= 25; t++) begin
         step();
         chk($sformatf("ab_done@%0d", t), 32'(bus.done), 0);
         chk($sformatf("ab_busy@%0d", t), 32'(bus.busy), (t < 20) ? 1 : 0);
         chk($sformatf("ab_rem@%0d", t), 32'(bus.remaining), (t < 20) ? 20 - t : 0);
         if (t == 19) bus.abort = 1'b1;
         if (t == 20) bus.abort = 1'b0;
      end

      // Abort together with start in IDLE stays IDLE
      bus.start = 1'b1;
      bus.abort = 1'b1;
      step();
      chk("abst_busy", 32'(bus.busy), 0);
      chk("abst_rem",  32'(bus.remaining), 0);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      step();
      chk("abst_busy2", 32'(bus.busy), 0);

      // delay_val=0 without default behaves as D=1
      setup(18'd0, 8'd0, 1'b0, 1'b0);
      pulse_start();
      chk("zero_rem0", 32'(bus.remaining), 1);
      step();
      chk("zero_done1", 32'(bus.done), 1);
      chk("zero_busy1", 32'(bus.busy), 0);
      step();
      chk("zero_done2", 32'(bus.done), 0);

      // Legacy: held start, periodic, default delay; held start must not retrigger in RUN
      setup(18'd0, 8'd0, 1'b1, 1'b1);
      bus.start = 1'b1;
      step();
      chk("dflt_rem0",  32'(bus.remaining), 200000);
      chk("dflt_busy0", 32'(bus.busy), 1);
      repeat (10) step();
      chk("dflt_rem10",  32'(bus.remaining), 199990);
      chk("dflt_busy10", 32'(bus.busy), 1);
      bus.abort = 1'b1;
      bus.start = 1'b0;
      step();
      chk("dflt_abort_busy", 32'(bus.busy), 0);
      chk("dflt_abort_rem",  32'(bus.remaining), 0);
      bus.abort = 1'b0;
      step();

      // Async reset mid-run clears everything immediately, then a fresh start works
      setup(18'd50, 8'd0, 1'b0, 1'b0);
      pulse_start();
      repeat (20) step();
      chk("mr_rem20", 32'(bus.remaining), 30);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mr_busy", 32'(bus.busy), 0);
      chk("mr_done", 32'(bus.done), 0);
      chk("mr_rem",  32'(bus.remaining), 0);
      for (int t = 1; t <= 40; t++) begin
         step();
         if (t == 10) reset_n = 1'b1;
         chk($sformatf("mr_nodone@%0d", t), 32'(bus.done), 0);
      end
      setup(18'd3, 8'd0, 1'b0, 1'b0);
      pulse_start();
      for (int t = 1; t <= 6; t++) begin
         step();
         chk($sformatf("mr_post_done@%0d", t), 32'(bus.done), (t == 3) ? 1 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
